// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display driver.
// All segment, decimal-point and anode values are active-low.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_state_e;

  typedef logic [1:0] digit_t;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_pat_t;

  localparam seg_pat_t PAT_BLANK = '{seg: SEG_BLANK, dp: 1'b1};

  // One anode low (active) for the given digit, all others high.
  function automatic logic [3:0] anode_for(digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot timing: a blanking gap followed by a drive window, stepping through
// digits 0..3. frame_end marks the last drive cycle of digit 3.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output slot_state_e state,
  output digit_t      digit,
  output logic        frame_end
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] count, count_next;
  slot_state_e   state_next;
  digit_t        digit_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SLOT_BLANK;
      count <= '0;
      digit <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      digit <= digit_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    count_next = count + 1'b1;
    digit_next = digit;
    if (!enable) begin
      state_next = SLOT_BLANK;
      count_next = '0;
      digit_next = '0;
    end else begin
      unique case (state)
        SLOT_BLANK: if (count == BLANK_LAST) state_next = SLOT_DRIVE;
        SLOT_DRIVE: if (count == SLOT_LAST) begin
          count_next = '0;
          digit_next = digit + 1'b1;
          state_next = SLOT_BLANK;
        end
        default: state_next = SLOT_BLANK;
      endcase
    end
  end

  always_comb begin
    frame_end = enable && (state == SLOT_DRIVE) && (count == SLOT_LAST) && (digit == 2'd3);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Tear-free 4-digit 7-segment scan driver: writes land in a shadow buffer and are
// swapped into the live frame only at a frame boundary (or at once while dark).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_digit,
  input  logic [6:0] wr_seg,
  input  logic       wr_dp,
  input  logic       commit,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  slot_state_e state;
  digit_t      digit;
  logic        frame_end;
  seg_pat_t    shadow [4];
  seg_pat_t    live   [4];
  logic        commit_pending;
  logic        swap;

  seg_slot_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .state    (state),
    .digit    (digit),
    .frame_end(frame_end)
  );

  assign wr_ready = ~commit_pending;
  // Nothing is visible while disabled, so a pending swap need not wait for a boundary.
  assign swap     = commit_pending & (frame_end | ~enable);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: these buffers are tiny and must come up blank, so they are reset
      // explicitly; a large RAM would normally be left unreset.
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= PAT_BLANK;
        live[i]   <= PAT_BLANK;
      end
    end else begin
      if (wr_valid && wr_ready) shadow[wr_digit] <= '{seg: wr_seg, dp: wr_dp};
      if (swap) live <= shadow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       commit_pending <= 1'b0;
    else if (swap)   commit_pending <= 1'b0;
    else if (commit) commit_pending <= 1'b1;
  end

  // seg/dp follow the current digit during its blanking gap too, so they only
  // ever change while every anode is off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode      <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (enable) begin
        anode <= (state == SLOT_DRIVE) ? anode_for(digit) : ANODE_OFF;
        seg   <= live[digit].seg;
        dp    <= live[digit].dp;
      end else begin
        anode <= ANODE_OFF;
        seg   <= SEG_BLANK;
        dp    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a frame-position model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_seg_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_digit = 2'd0;
  logic [6:0] wr_seg = 7'h7F;
  logic       wr_dp = 1'b1;
  logic       commit = 1'b0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_digit  (wr_digit),
    .wr_seg    (wr_seg),
    .wr_dp     (wr_dp),
    .commit    (commit),
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the display is a function of the position within the frame (cycles
  // since scanning started), the live buffer, and enable.
  typedef struct packed {
    logic [6:0] s;
    logic       d;
  } pat_t;

  pat_t       m_shadow [4] = '{default: '{s: 7'h7F, d: 1'b1}};
  pat_t       m_live   [4] = '{default: '{s: 7'h7F, d: 1'b1}};
  bit         m_pending = 1'b0;
  int         m_pos = 0;
  logic [3:0] e_anode = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;
  logic       e_tick = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_shadow  <= '{default: '{s: 7'h7F, d: 1'b1}};
      m_live    <= '{default: '{s: 7'h7F, d: 1'b1}};
      m_pending <= 1'b0;
      m_pos     <= 0;
      e_anode   <= 4'hF;
      e_seg     <= 7'h7F;
      e_dp      <= 1'b1;
      e_tick    <= 1'b0;
    end else begin
      if (enable) begin
        e_anode <= ((m_pos % SD) >= BC) ? 4'(~(4'b0001 << (m_pos / SD))) : 4'hF;
        e_seg   <= m_live[m_pos / SD].s;
        e_dp    <= m_live[m_pos / SD].d;
        e_tick  <= (m_pos == FRAME - 1);
      end else begin
        e_anode <= 4'hF;
        e_seg   <= 7'h7F;
        e_dp    <= 1'b1;
        e_tick  <= 1'b0;
      end
      if (wr_valid && !m_pending) m_shadow[wr_digit] <= '{s: wr_seg, d: wr_dp};
      if (m_pending && (!enable || m_pos == FRAME - 1)) begin
        m_live    <= m_shadow;
        m_pending <= 1'b0;
      end else if (commit && !m_pending) begin
        m_pending <= 1'b1;
      end
      m_pos <= enable ? (m_pos + 1) % FRAME : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_anode", anode, e_anode);
      check("m_seg", seg, e_seg);
      check("m_dp", dp, e_dp);
      check("m_tick", frame_tick, e_tick);
      check("m_ready", wr_ready, !m_pending);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] d, input logic [6:0] s, input logic p);
    wr_valid = 1'b1; wr_digit = d; wr_seg = s; wr_dp = p;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 200);
    check("tick_seen", frame_tick, 1);
  endtask

  logic [3:0] exp_an [17] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE,
                              4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};

  initial begin
    int n;
    // Reset state
    step(2);
    chk_on = 1'b1;
    check("rst_anode", anode, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_tick", frame_tick, 0);
    check("rst_ready", wr_ready, 1);
    reset = 1'b0;
    step(2);

    // Scan start: 3 dark, 6 on digit 0, 2 dark, 6 on digit 1
    enable = 1'b1;
    check("scan_an_0", anode, exp_an[0]);
    for (int i = 1; i < 17; i++) begin
      step();
      check($sformatf("scan_an_%0d", i), anode, exp_an[i]);
      check($sformatf("scan_seg_%0d", i), seg, 7'h7F);
    end

    // Write d0/d1, commit; swap only at the boundary
    write(2'd0, 7'h3F, 1'b1);
    write(2'd1, 7'h06, 1'b1);
    pulse_commit();
    check("commit_ready_low", wr_ready, 0);
    wait_tick(n);
    check("boundary_ready_high", wr_ready, 1);
    step(3);
    check("d0_anode", anode, 4'hE);
    check("d0_seg", seg, 7'h3F);
    step(8);
    check("d1_anode", anode, 4'hD);
    check("d1_seg", seg, 7'h06);

    // Commit mid-digit-1; writes while pending are dropped
    step();
    pulse_commit();
    check("mid_ready_low", wr_ready, 0);
    wr_valid = 1'b1; wr_digit = 2'd2; wr_seg = 7'h12; wr_dp = 1'b0;
    step(3);
    wr_valid = 1'b0;
    step(15);
    check("pre_tick_ready", wr_ready, 0);
    check("pre_tick", frame_tick, 0);
    step();
    check("tick_rise", frame_tick, 1);
    check("tick_ready_rise", wr_ready, 1);
    step(19);
    check("d2_anode", anode, 4'hB);
    check("d2_dropped_seg", seg, 7'h7F);

    // Write + commit in the same cycle on d3
    wr_valid = 1'b1; wr_digit = 2'd3; wr_seg = 7'h00; wr_dp = 1'b0; commit = 1'b1;
    step();
    wr_valid = 1'b0; commit = 1'b0;
    step(7);
    check("d3_before_anode", anode, 4'h7);
    check("d3_before_seg", seg, 7'h7F);
    check("d3_before_dp", dp, 1);
    step(5);
    check("d3_tick", frame_tick, 1);
    step(27);
    check("d3_after_seg", seg, 7'h00);
    check("d3_after_dp", dp, 0);

    // Disable with a commit pending: immediate swap, dark display
    write(2'd1, 7'h5B, 1'b1);
    pulse_commit();
    enable = 1'b0;
    step();
    check("dis_anode", anode, 4'hF);
    check("dis_seg", seg, 7'h7F);
    check("dis_ready", wr_ready, 1);
    step(2);
    enable = 1'b1;
    step(11);
    check("reen_d1_anode", anode, 4'hD);
    check("reen_d1_seg", seg, 7'h5B);

    // Async reset in the middle of digit 2's drive window
    step(9);
    check("pre_rst_anode", anode, 4'hB);
    reset = 1'b1;
    #1;
    check("async_anode", anode, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dp", dp, 1);
    step(2);
    reset = 1'b0;
    step(3);
    check("post_rst_anode", anode, 4'hE);
    check("post_rst_d0_seg", seg, 7'h7F);
    step(24);
    check("post_rst_d3_anode", anode, 4'h7);
    check("post_rst_d3_seg", seg, 7'h7F);
    check("post_rst_d3_dp", dp, 1);
    wait_tick(n);
    check("first_frame_len", 27 + n, FRAME);
    wait_tick(n);
    check("frame_period", n, FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
